gpu_input_cond: RTL and testbench

GPU_INPUT_COND -- requirements
Module: gpu_input_cond

---
 rtl/gpu_input_cond.sv | 139 +++++++++++++
 tb/tb_gpu_input_cond.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_input_cond.sv
// Input conditioning for cabinet controls: synchronize, debounce, SOCD-neutralize
// joysticks and stretch coin switches into fixed-length frame pulses.
module gpu_input_cond #(
    parameter int unsigned DEB_DIV     = 4096,
    parameter int unsigned COIN_FRAMES = 4
) (
    input  logic       bus_clk,
    input  logic       bus_rst,
    input  logic       bus_eof,
    input  logic [1:0] raw_start_n,
    input  logic [1:0] raw_coin_n,
    input  logic [5:0] raw_joy1_n,
    input  logic [5:0] raw_joy2_n,
    output logic [1:0] start_n,
    output logic [1:0] coin_n,
    output logic [5:0] joy1_n,
    output logic [5:0] joy2_n
);

    localparam int unsigned NB = 16;
    localparam int unsigned PW = $clog2(DEB_DIV);
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        COIN_IDLE    = 2'd0,
        COIN_ACTIVE  = 2'd1,
        COIN_HOLDOFF = 2'd2
    } coin_state_t;

    // Bit map: [1:0] start, [3:2] coin, [9:4] joy1, [15:10] joy2
    logic [NB-1:0] raw_c;
    logic [NB-1:0] sync1, sync2;
    logic [NB-1:0] hist0, hist1, hist2;
    logic [NB-1:0] deb;
    logic [NB-1:0] agree_c;
    logic [PW-1:0] pre;
    logic          tick_c;

    logic [1:0]    deb_coin_c;
    logic [1:0]    coin_prev;
    logic [1:0]    press_c;
    coin_state_t   coin_st    [2];
    coin_state_t   coin_st_nx [2];
    logic [CW-1:0] coin_cnt    [2];
    logic [CW-1:0] coin_cnt_nx [2];

    assign raw_c   = {raw_joy2_n, raw_joy1_n, raw_coin_n, raw_start_n};
    assign tick_c  = (pre == PW'(DEB_DIV - 1));
    assign agree_c = ~(sync2 ^ hist0) & ~(sync2 ^ hist1) & ~(sync2 ^ hist2);

    // Opposing directions pressed together cancel to neutral
    function automatic logic [5:0] socd(input logic [5:0] j);
        logic [5:0] r;
        r = j;
        if (!j[0] && !j[1]) r[1:0] = 2'b11;
        if (!j[2] && !j[3]) r[3:2] = 2'b11;
        return r;
    endfunction

    // Synchronizer, prescaler and 4-sample agreement debouncer
    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            sync1 <= '1;
            sync2 <= '1;
            hist0 <= '1;
            hist1 <= '1;
            hist2 <= '1;
            deb   <= '1;
            pre   <= '0;
        end else begin
            sync1 <= raw_c;
            sync2 <= sync1;
            pre   <= tick_c ? '0 : pre + PW'(1);
            if (tick_c) begin
                hist0 <= sync2;
                hist1 <= hist0;
                hist2 <= hist1;
                deb   <= (deb & ~agree_c) | (sync2 & agree_c);
            end
        end
    end

    assign deb_coin_c = deb[3:2];
    assign press_c    = coin_prev & ~deb_coin_c;

    // Coin pulse stretchers; eof is ignored in IDLE so the arming cycle never counts
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            coin_st_nx[i]  = coin_st[i];
            coin_cnt_nx[i] = coin_cnt[i];
            case (coin_st[i])
                COIN_IDLE: begin
                    if (press_c[i]) begin
                        coin_st_nx[i]  = COIN_ACTIVE;
                        coin_cnt_nx[i] = '0;
                    end
                end
                COIN_ACTIVE: begin
                    if (bus_eof) begin
                        if (coin_cnt[i] == CW'(COIN_FRAMES - 1)) begin
                            coin_st_nx[i] = COIN_HOLDOFF;
                        end else begin
                            coin_cnt_nx[i] = coin_cnt[i] + CW'(1);
                        end
                    end
                end
                COIN_HOLDOFF: begin
                    if (deb_coin_c[i]) coin_st_nx[i] = COIN_IDLE;
                end
                default: coin_st_nx[i] = COIN_IDLE;
            endcase
        end
    end

    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            for (int i = 0; i < 2; i++) begin
                coin_st[i]  <= COIN_IDLE;
                coin_cnt[i] <= '0;
            end
            coin_prev <= 2'b11;
            coin_n    <= 2'b11;
            start_n   <= 2'b11;
            joy1_n    <= 6'h3f;
            joy2_n    <= 6'h3f;
        end else begin
            for (int i = 0; i < 2; i++) begin
                coin_st[i]  <= coin_st_nx[i];
                coin_cnt[i] <= coin_cnt_nx[i];
                coin_n[i]   <= (coin_st_nx[i] != COIN_ACTIVE);
            end
            coin_prev <= deb_coin_c;
            start_n   <= deb[1:0];
            joy1_n    <= socd(deb[9:4]);
            joy2_n    <= socd(deb[15:10]);
        end
    end

endmodule

// File: tb/tb_gpu_input_cond.sv
// Scoreboard bench for gpu_input_cond: stimulus queues expected level changes and
// coin pulse lengths; a negedge monitor pops and compares as outputs move.
module tb_gpu_input_cond;

    localparam int unsigned DEB_DIV     = 4;
    localparam int unsigned COIN_FRAMES = 4;
    localparam int LAT_MIN = 2 + 3 * DEB_DIV + 2;
    localparam int LAT_MAX = 2 + 4 * DEB_DIV + 2;

    logic       bus_clk = 1'b0;
    logic       bus_rst = 1'b1;
    logic       bus_eof = 1'b0;
    logic [1:0] raw_start_n = 2'b11;
    logic [1:0] raw_coin_n  = 2'b11;
    logic [5:0] raw_joy1_n  = 6'h3f;
    logic [5:0] raw_joy2_n  = 6'h3f;
    logic [1:0] start_n, coin_n;
    logic [5:0] joy1_n, joy2_n;

    gpu_input_cond #(.DEB_DIV(DEB_DIV), .COIN_FRAMES(COIN_FRAMES)) dut (
        .bus_clk(bus_clk), .bus_rst(bus_rst), .bus_eof(bus_eof),
        .raw_start_n(raw_start_n), .raw_coin_n(raw_coin_n),
        .raw_joy1_n(raw_joy1_n), .raw_joy2_n(raw_joy2_n),
        .start_n(start_n), .coin_n(coin_n), .joy1_n(joy1_n), .joy2_n(joy2_n)
    );

    always #5 bus_clk = ~bus_clk;

    int cyc = 0;
    always @(posedge bus_clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [13:0] val;
        int          t;
    } lvl_exp_t;

    lvl_exp_t    lvl_q[$];
    int          coin_q0[$];
    int          coin_q1[$];
    logic [13:0] last_exp = '1;
    logic        mon_en = 1'b0;
    int          eof_every = 0;
    int          eof_req = 0;

    // Frame-end generator: periodic (eof_every) or a counted burst (eof_req)
    initial begin
        forever begin
            @(posedge bus_clk);
            #1;
            if (eof_every > 0 && (cyc % eof_every) == 0) begin
                bus_eof = 1'b1;
            end else if (eof_req > 0) begin
                bus_eof = 1'b1;
                eof_req = eof_req - 1;
            end else begin
                bus_eof = 1'b0;
            end
        end
    end

    function automatic logic [5:0] neutral(input logic [5:0] j);
        logic [5:0] r;
        r = j;
        if (j[1:0] == 2'b00) r[1:0] = 2'b11;
        if (j[3:2] == 2'b00) r[3:2] = 2'b11;
        return r;
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic apply(input logic [1:0] st, input logic [5:0] j1, input logic [5:0] j2);
        logic [13:0] e;
        lvl_exp_t    x;
        @(posedge bus_clk);
        #1;
        raw_start_n = st;
        raw_joy1_n  = j1;
        raw_joy2_n  = j2;
        e = {st, neutral(j1), neutral(j2)};
        if (e != last_exp) begin
            x.val = e;
            x.t   = cyc;
            lvl_q.push_back(x);
            last_exp = e;
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge bus_clk);
    endtask

    task automatic wait_coin_low(input int i);
        int n;
        n = 0;
        while (coin_n[i] !== 1'b0 && n < 60) begin
            @(negedge bus_clk);
            n++;
        end
        tests++;
        if (coin_n[i] !== 1'b0) begin
            fails++;
            $display("FAIL coin%0d_start_timeout: coin_n=%b after %0d cycles, required 0", i, coin_n, n);
        end
    endtask

    // Monitor: level outputs and coin pulse lengths (eofs seen while coin_n low)
    logic [13:0] prev_out = '1;
    logic [1:0]  coin_prev_s = 2'b11;
    int          ccount [2];
    always @(negedge bus_clk) begin
        logic [13:0] cur;
        lvl_exp_t    e;
        int          d, want;
        if (mon_en) begin
            cur = {start_n, joy1_n, joy2_n};
            if (cur != prev_out) begin
                tests++;
                if (lvl_q.size() == 0) begin
                    fails++;
                    $display("FAIL lvl_unexpected: got %b, required %b (no change)", cur, prev_out);
                end else begin
                    e = lvl_q.pop_front();
                    d = cyc - e.t;
                    if (cur !== e.val) begin
                        fails++;
                        $display("FAIL lvl_value: got %b, required %b", cur, e.val);
                    end
                    tests++;
                    if (d < LAT_MIN || d > LAT_MAX) begin
                        fails++;
                        $display("FAIL lvl_latency: got %0d cycles, required %0d..%0d", d, LAT_MIN, LAT_MAX);
                    end
                end
                prev_out = cur;
            end
            for (int i = 0; i < 2; i++) begin
                if (coin_n[i] == 1'b0) begin
                    if (coin_prev_s[i]) ccount[i] = 0;
                    if (bus_eof) ccount[i] = ccount[i] + 1;
                end else if (!coin_prev_s[i]) begin
                    tests++;
                    if ((i == 0 && coin_q0.size() == 0) || (i == 1 && coin_q1.size() == 0)) begin
                        fails++;
                        $display("FAIL coin%0d_unexpected_pulse: got %0d frames, required no pulse", i, ccount[i]);
                    end else begin
                        want = (i == 0) ? coin_q0.pop_front() : coin_q1.pop_front();
                        if (ccount[i] != want) begin
                            fails++;
                            $display("FAIL coin%0d_len: got %0d frames, required %0d", i, ccount[i], want);
                        end
                    end
                end
                coin_prev_s[i] = coin_n[i];
            end
        end
    end

    initial begin
        logic seen_low;

        wait_cyc(3);
        #1;
        check("reset_outputs", {start_n, coin_n, joy1_n, joy2_n}, 16'hffff);
        bus_rst = 1'b0;
        mon_en  = 1'b1;

        // Button press/release, start press, then a short glitch that must be ignored
        apply(2'b11, 6'b101111, 6'h3f); wait_cyc(30);
        apply(2'b11, 6'h3f, 6'h3f);     wait_cyc(30);
        apply(2'b01, 6'h3f, 6'h3f);     wait_cyc(30);
        apply(2'b11, 6'h3f, 6'h3f);     wait_cyc(30);
        @(posedge bus_clk); #1;
        raw_start_n[0] = 1'b0;
        wait_cyc(3); #1;
        raw_start_n[0] = 1'b1;
        wait_cyc(30);
        check("glitch_start", {14'd0, start_n}, 16'h0003);

        // SOCD: both horizontal pressed -> neutral; release right -> left only
        apply(2'b11, 6'h3f, 6'b111100); wait_cyc(30);
        check("socd_lr_both", {10'd0, joy2_n}, 16'h003f);
        apply(2'b11, 6'h3f, 6'b111101); wait_cyc(30);
        check("socd_left_only", {14'd0, joy2_n[1:0]}, 16'h0001);
        apply(2'b11, 6'h3f, 6'h3f);     wait_cyc(30);
        apply(2'b11, 6'b110111, 6'h3f); wait_cyc(30);
        apply(2'b11, 6'b110011, 6'h3f); wait_cyc(30);
        apply(2'b11, 6'b111011, 6'h3f); wait_cyc(30);
        check("socd_down_only", {10'd0, joy1_n}, 16'h003b);
        apply(2'b11, 6'h3f, 6'h3f);     wait_cyc(30);

        // Coin0 held ~10 frames: one 4-frame pulse, no retrigger; then re-press
        eof_every = 8;
        coin_q0.push_back(COIN_FRAMES);
        @(posedge bus_clk); #1; raw_coin_n[0] = 1'b0;
        wait_cyc(110);
        check("coin0_holdoff", {14'd0, coin_n}, 16'h0003);
        @(posedge bus_clk); #1; raw_coin_n[0] = 1'b1;
        wait_cyc(30);
        coin_q0.push_back(COIN_FRAMES);
        @(posedge bus_clk); #1; raw_coin_n[0] = 1'b0;
        wait_cyc(80);
        @(posedge bus_clk); #1; raw_coin_n[0] = 1'b1;
        wait_cyc(30);

        // Coin1 released as soon as its pulse starts: length unchanged
        coin_q1.push_back(COIN_FRAMES);
        @(posedge bus_clk); #1; raw_coin_n[1] = 1'b0;
        wait_coin_low(1);
        @(posedge bus_clk); #1; raw_coin_n[1] = 1'b1;
        wait_cyc(60);

        // eof every cycle: arming eof must not count; both coins pulse independently
        eof_every = 1;
        coin_q0.push_back(COIN_FRAMES);
        coin_q1.push_back(COIN_FRAMES);
        @(posedge bus_clk); #1; raw_coin_n = 2'b00;
        wait_coin_low(0);
        check("coin_both_low", {14'd0, coin_n}, 16'h0000);
        wait_cyc(30);
        @(posedge bus_clk); #1; raw_coin_n = 2'b11;
        wait_cyc(30);

        // Reset mid-pulse aborts it; held coin re-pulses only after a full window
        eof_every = 0;
        coin_q0.push_back(2);
        @(posedge bus_clk); #1; raw_coin_n[0] = 1'b0;
        wait_coin_low(0);
        eof_req = 2;
        wait_cyc(6);
        @(posedge bus_clk); #1; bus_rst = 1'b1;
        @(posedge bus_clk); #1;
        check("reset_midpulse", {start_n, coin_n, joy1_n, joy2_n}, 16'hffff);
        bus_rst = 1'b0;
        coin_q0.push_back(COIN_FRAMES);
        seen_low = 1'b0;
        repeat (3 * DEB_DIV) begin
            @(negedge bus_clk);
            if (coin_n[0] == 1'b0) seen_low = 1'b1;
        end
        check("coin0_no_early_repulse", {15'd0, seen_low}, 16'h0000);
        eof_every = 8;
        wait_cyc(80);
        @(posedge bus_clk); #1; raw_coin_n[0] = 1'b1;
        wait_cyc(30);

        check("lvl_queue_drained", 16'(lvl_q.size()), 16'h0000);
        check("coin0_queue_drained", 16'(coin_q0.size()), 16'h0000);
        check("coin1_queue_drained", 16'(coin_q1.size()), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
